// File: rtl/tcdm_responder_bank.sv
// rtl/tcdm_responder_bank.sv - multi-port TCDM slave over one word SRAM, round-robin, fixed read latency
module tcdm_responder_bank #(
  parameter int          MP        = 4,
  parameter int          MEM_WORDS = 1024,
  parameter int          LAT       = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic [MP-1:0]      tcdm_req_i,
  output logic [MP-1:0]      tcdm_gnt_o,
  input  logic [MP*32-1:0]   tcdm_add_i,
  input  logic [MP-1:0]      tcdm_wen_i,
  input  logic [MP*4-1:0]    tcdm_be_i,
  input  logic [MP*32-1:0]   tcdm_data_i,
  output logic [MP*32-1:0]   tcdm_r_data_o,
  output logic [MP-1:0]      tcdm_r_valid_o,
  output logic [15:0]        err_cnt_o
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam int          PW   = (MP > 1) ? $clog2(MP) : 1;
  localparam logic [31:0] SPAN = 32'(MEM_WORDS * 4);
  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  logic [31:0]   mem [MEM_WORDS];

  logic [PW-1:0] ptr;
  logic          gnt_any;
  logic [PW-1:0] gnt_idx;

  logic [31:0]   sel_add;
  logic          sel_wen;
  logic [3:0]    sel_be;
  logic [31:0]   sel_data;
  logic [32:0]   off_ext;
  logic          in_range;
  logic [AW-1:0] widx;
  logic [31:0]   rd_word;

  // Response pipeline; the last stage drives the r_valid pulse directly.
  logic          pv [LAT];
  logic [PW-1:0] pp [LAT];
  logic [31:0]   pd [LAT];
  logic [31:0]   hold [MP];

  // Round-robin search from ptr; stall and reset suppress every grant.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < MP; i++) begin
      cand = int'(ptr) + i;
      if (cand >= MP) cand = cand - MP;
      if (!gnt_any && tcdm_req_i[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(cand);
      end
    end
    if (stall_i || rst_i) gnt_any = 1'b0;
  end

  assign tcdm_gnt_o = gnt_any ? (MP'(1) << gnt_idx) : '0;

  // Mux the granted port's request and decode it against the window.
  always_comb begin
    sel_add  = tcdm_add_i[32*gnt_idx +: 32];
    sel_wen  = tcdm_wen_i[gnt_idx];
    sel_be   = tcdm_be_i[4*gnt_idx +: 4];
    sel_data = tcdm_data_i[32*gnt_idx +: 32];
    off_ext  = {1'b0, sel_add} - {1'b0, BASE_ADDR};
    in_range = !off_ext[32] && (off_ext[31:0] < SPAN);
    widx     = off_ext[AW+1:2];
    rd_word  = mem[widx];
  end

  // Byte-masked SRAM write; out-of-range writes are dropped, contents survive reset.
  always_ff @(posedge clk_i) begin
    if (gnt_any && !sel_wen && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_be[b]) mem[widx][8*b +: 8] <= sel_data[8*b +: 8];
      end
    end
  end

  // Read-response shift register; reset flushes anything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] <= 1'b0;
        pp[i] <= '0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= gnt_any && sel_wen;
      pp[0] <= gnt_idx;
      pd[0] <= in_range ? rd_word : OOR_DATA;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pp[i] <= pp[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  // Per-port valid pulse and held read data.
  always_comb begin
    for (int k = 0; k < MP; k++) begin
      tcdm_r_valid_o[k] = !rst_i && pv[LAT-1] && (pp[LAT-1] == PW'(k));
      if (rst_i)
        tcdm_r_data_o[32*k +: 32] = '0;
      else if (tcdm_r_valid_o[k])
        tcdm_r_data_o[32*k +: 32] = pd[LAT-1];
      else
        tcdm_r_data_o[32*k +: 32] = hold[k];
    end
  end

  // Capture the delivered word so r_data stays put between pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < MP; k++) hold[k] <= '0;
    end else begin
      for (int k = 0; k < MP; k++) begin
        if (tcdm_r_valid_o[k]) hold[k] <= pd[LAT-1];
      end
    end
  end

  // Advance the round-robin pointer past the granted port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (int'(gnt_idx) == MP - 1) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Saturating count of out-of-range transactions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_o <= '0;
    end else if (gnt_any && !in_range && err_cnt_o != 16'hFFFF) begin
      err_cnt_o <= err_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_tcdm_responder_bank.sv
// tb/tb_tcdm_responder_bank.sv - directed self-checking bench for tcdm_responder_bank at LAT 1, 2 and 3
module tb_tcdm_responder_bank;

  logic         clk;
  logic         rst;
  logic         stall;
  logic [3:0]   req;
  logic [127:0] add;
  logic [3:0]   wen;
  logic [15:0]  be;
  logic [127:0] wdata;

  logic [3:0]   gnt1, gnt2, gnt3;
  logic [127:0] rd1, rd2, rd3;
  logic [3:0]   rv1, rv2, rv3;
  logic [15:0]  err1, err2, err3;

  int n_vec = 0;
  int n_err = 0;

  tcdm_responder_bank #(.MP(4), .MEM_WORDS(1024), .LAT(1), .BASE_ADDR(32'h0)) dut1 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .tcdm_req_i(req), .tcdm_gnt_o(gnt1),
    .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_data_o(rd1), .tcdm_r_valid_o(rv1), .err_cnt_o(err1));

  tcdm_responder_bank #(.MP(4), .MEM_WORDS(1024), .LAT(2), .BASE_ADDR(32'h0)) dut2 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .tcdm_req_i(req), .tcdm_gnt_o(gnt2),
    .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_data_o(rd2), .tcdm_r_valid_o(rv2), .err_cnt_o(err2));

  tcdm_responder_bank #(.MP(4), .MEM_WORDS(1024), .LAT(3), .BASE_ADDR(32'h0)) dut3 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .tcdm_req_i(req), .tcdm_gnt_o(gnt3),
    .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_data_o(rd3), .tcdm_r_valid_o(rv3), .err_cnt_o(err3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int k, input logic [31:0] a, input logic w,
                     input logic [3:0] b, input logic [31:0] d);
    add[32*k +: 32]   = a;
    wen[k]            = w;
    be[4*k +: 4]      = b;
    wdata[32*k +: 32] = d;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; req = 4'hF; add = '0; wen = 4'hF; be = '0; wdata = '0;
    cyc; cyc; #1;
    chk("rst_gnt", 32'(gnt1), 32'h0);
    chk("rst_rvalid", 32'(rv1), 32'h0);
    chk("rst_rdata", rd1[31:0], 32'h0);
    chk("rst_err", 32'(err1), 32'h0);

    cyc; rst = 1'b0; req = 4'b0001;
    drv(0, 32'h40, 1'b0, 4'hF, 32'hCAFE_F00D); #1;
    chk("wr_gnt", 32'(gnt1), 32'h1);
    cyc; drv(0, 32'h40, 1'b1, 4'h0, 32'h0); #1;
    chk("rd_gnt", 32'(gnt1), 32'h1);
    chk("rd_not_early", 32'(rv1), 32'h0);
    cyc; drv(0, 32'h40, 1'b0, 4'hF, 32'h1122_3344); #1;
    chk("raw_rvalid", 32'(rv1), 32'h1);
    chk("raw_rdata", rd1[31:0], 32'hCAFE_F00D);
    cyc; drv(0, 32'h40, 1'b0, 4'b0101, 32'hAABB_CCDD); #1;
    chk("rvalid_pulse", 32'(rv1), 32'h0);
    chk("rdata_hold", rd1[31:0], 32'hCAFE_F00D);
    cyc; drv(0, 32'h40, 1'b1, 4'h0, 32'h0); #1;
    chk("lat3_first_rvalid", 32'(rv3), 32'h1);
    chk("lat3_first_rdata", rd3[31:0], 32'hCAFE_F00D);
    cyc; req = 4'b0000; #1;
    chk("be_rvalid", 32'(rv1), 32'h1);
    chk("be_rdata", rd1[31:0], 32'h11BB_33DD);
    chk("lat3_idle1", 32'(rv3), 32'h0);
    cyc; #1;
    chk("lat2_rvalid", 32'(rv2), 32'h1);
    chk("lat2_rdata", rd2[31:0], 32'h11BB_33DD);
    chk("lat3_idle2", 32'(rv3), 32'h0);
    cyc; #1;
    chk("lat3_rvalid", 32'(rv3), 32'h1);
    chk("lat3_rdata", rd3[31:0], 32'h11BB_33DD);

    rst = 1'b1; req = 4'hF;
    for (int k = 0; k < 4; k++) drv(k, 32'h80 + 32'(4 * k), 1'b1, 4'h0, 32'h0);
    #1;
    chk("rst_gnt_again", 32'(gnt1), 32'h0);
    cyc; rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_all", 32'(gnt1), 32'(1) << (i % 4));
      cyc;
    end
    req = 4'b0010; #1;
    chk("rr_p1_alone", 32'(gnt1), 32'h2);
    cyc; req = 4'b1010; #1;
    chk("rr_p3_first", 32'(gnt1), 32'h8);
    cyc; #1;
    chk("rr_p1_next", 32'(gnt1), 32'h2);

    cyc; req = 4'b1011; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_gnt", 32'(gnt1), 32'h0);
      cyc;
    end
    stall = 1'b0; #1;
    chk("stall_resume", 32'(gnt1), 32'h8);
    cyc; #1;
    chk("stall_after", 32'(gnt1), 32'h1);

    cyc; req = 4'b0100; drv(2, 32'h0, 1'b0, 4'hF, 32'h55AA_55AA); #1;
    chk("pre_gnt", 32'(gnt1), 32'h4);
    cyc; drv(2, 32'h1000, 1'b1, 4'h0, 32'h0); #1;
    chk("oor_rd_gnt", 32'(gnt1), 32'h4);
    cyc; drv(2, 32'h1000, 1'b0, 4'hF, 32'h1234_5678); #1;
    chk("oor_rvalid", 32'(rv1), 32'h4);
    chk("oor_rdata", rd1[95:64], 32'hDEAD_BEEF);
    chk("oor_err1", 32'(err1), 32'h1);
    chk("oor_wr_gnt", 32'(gnt1), 32'h4);
    cyc; drv(2, 32'h0, 1'b1, 4'h0, 32'h0); #1;
    chk("oor_err2", 32'(err1), 32'h2);
    cyc; req = 4'b0000; #1;
    chk("oor_mem_rvalid", 32'(rv1), 32'h4);
    chk("oor_mem_kept", rd1[95:64], 32'h55AA_55AA);

    cyc; req = 4'b0001; drv(0, 32'h40, 1'b1, 4'h0, 32'h0); #1;
    chk("mid_rd_gnt", 32'(gnt2), 32'h1);
    cyc; rst = 1'b1; req = 4'hF; #1;
    chk("mid_rst_gnt", 32'(gnt2), 32'h0);
    chk("mid_rst_rv", 32'(rv2), 32'h0);
    cyc; rst = 1'b0; req = 4'b1001; drv(3, 32'h80, 1'b1, 4'h0, 32'h0); #1;
    chk("rst_drop_lat2", 32'(rv2), 32'h0);
    chk("ptr_after_rst", 32'(gnt2), 32'h1);
    chk("err_after_rst", 32'(err2), 32'h0);
    cyc; req = 4'b0000; #1;
    chk("rst_drop_lat3", 32'(rv3), 32'h0);
    chk("post_rst_early", 32'(rv2), 32'h0);
    cyc; #1;
    chk("post_rst_rvalid", 32'(rv2), 32'h1);
    chk("post_rst_rdata", rd2[31:0], 32'h11BB_33DD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
